spi_read_fetcher: RTL and testbench
===================================

SPI_READ_FETCHER -- requirements
Module: spi_read_fetcher

Interface
REQ-001 SHALL have parameter CMD_BYTE, default 8'h03, meaning the SPI read opcode sent first.
REQ-002 SHALL have port clk  input  1  system clock; all logic is clocked on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-005 SHALL have port addr  input  24  flash byte address, captured with start.
REQ-006 SHALL have port len  input  4  bytes to read; 0 means 16, captured with start.
REQ-007 SHALL have port abort  input  1  synchronous cancel of any transaction.
REQ-008 SHALL have port busy  output  1  high from the cycle after start acceptance through DONE.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port byte_valid  output  1  one-cycle strobe for each received byte.
REQ-011 SHALL have port byte_data  output  8  received byte, valid with byte_valid and held until the next byte.
REQ-012 SHALL have port byte_index  output  4  index of byte_data, 0..len-1.
REQ-013 SHALL have port spi_cs  output  1  chip select, active HIGH; the top level inverts it.
REQ-014 SHALL have port spi_sclk  output  1  SPI clock, mode 0, idle low.
REQ-015 SHALL have port spi_out0  output  1  io[0] MOSI data.
REQ-016 SHALL have port spi_dir0  output  1  io[0] direction: 0=output, 1=input.
REQ-017 SHALL have port spi_in1  input  1  io[1] MISO data.

Function
REQ-018 SHALL implement the states IDLE, CMD (8 bits), ADDR (24 bits), DATA (8*len bits) and DONE (1 cycle).
REQ-019 SHALL accept start in IDLE only, capture addr and len on that edge, and enter CMD with spi_cs=1 on the next cycle; start is ignored in all other states.
REQ-020 SHALL clock each SPI bit over 2 clk cycles: phase A with spi_sclk=0 and spi_out0 driven stable, then phase B with spi_sclk=1.
REQ-021 SHALL shift CMD_BYTE and then addr[23:0] out MSB-first, with spi_dir0=0 for the whole of CMD and ADDR.
REQ-022 SHALL set spi_dir0=1 and spi_out0=0 in DATA, DONE and IDLE.
REQ-023 SHALL sample spi_in1 on the clk edge that ends phase B and shift it into byte_data MSB-first.
REQ-024 SHALL pulse byte_valid on the cycle after the 8th bit of each byte is sampled; byte_index increments after each byte and starts at 0.
REQ-025 SHALL, after the final byte, enter DONE: spi_cs=0, spi_sclk=0, done=1, busy=1 for 1 cycle, then return to IDLE with busy=0.
REQ-026 SHALL make the total duration from the first CMD cycle to the last DATA cycle exactly 2*(32+8*N) clk cycles, where N=len (16 if len=0).
REQ-027 SHALL, on abort=1 in any non-IDLE state, go to IDLE on the next edge with spi_cs=0, spi_sclk=0, busy=0, and produce no done or further byte_valid; abort in IDLE has no effect.
REQ-028 SHALL give abort priority if abort and the final sample occur in the same cycle: no done and no byte_valid for that byte.
REQ-029 SHALL not block a start in the cycle directly after DONE; that start is accepted.

Reset
REQ-030 SHALL, while rst_n=0 and independent of clk, force state IDLE, spi_cs=0, spi_sclk=0, spi_out0=0, spi_dir0=1, busy=0, done=0, byte_valid=0, byte_data=0, byte_index=0.
REQ-031 SHALL, on reset asserted mid-transaction, drop spi_cs immediately and resume only on a new start after rst_n=1.

Verification
REQ-032 SHALL be verified with: start, addr=24'h123456, len=2, flash model returning A5,3C -> MOSI bits 03 12 34 56, byte_valid with A5 (idx 0) then 3C (idx 1), done at cycle 2*(32+16)+1 after start.
REQ-033 SHALL be verified with: len=0, incrementing model data -> 16 byte_valid pulses, idx 0..15, then 1 done.
REQ-034 SHALL be verified with: abort asserted during ADDR bit 10 -> spi_cs=0 the next cycle, no byte_valid, no done, busy=0.
REQ-035 SHALL be verified with: start pulsed during DATA -> ignored, byte count unchanged, single done.
REQ-036 SHALL be verified with: rst_n low mid-DATA -> spi_cs=0 and spi_sclk=0 without a clk edge, all outputs at reset values.
REQ-037 SHALL be verified with: start in the cycle after done -> new transaction accepted, spi_cs high the next cycle.

Source files
------------

// File: rtl/spi_read_fetcher.sv
// SPI flash read sequencer: sends CMD_BYTE and a 24-bit address on io[0], then
// clocks in len bytes from io[1] and presents each one with a strobe.
module spi_read_fetcher #(
  parameter logic [7:0] CMD_BYTE = 8'h03
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic [3:0]  len,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic [3:0]  byte_index,
  output logic        spi_cs,
  output logic        spi_sclk,
  output logic        spi_out0,
  output logic        spi_dir0,
  input  logic        spi_in1
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        phase_q, phase_d;      // 0 = phase A (sclk low), 1 = phase B
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic [4:0]  len_q, len_d;          // byte count 1..16
  logic [4:0]  byte_cnt_q, byte_cnt_d;
  logic        byte_valid_q, byte_valid_d;
  logic [7:0]  byte_data_q, byte_data_d;
  logic [3:0]  byte_index_q, byte_index_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      phase_q      <= 1'b0;
      bit_cnt_q    <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      len_q        <= '0;
      byte_cnt_q   <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      byte_index_q <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      len_q        <= len_d;
      byte_cnt_q   <= byte_cnt_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      byte_index_q <= byte_index_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    bit_cnt_d    = bit_cnt_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    len_d        = len_q;
    byte_cnt_d   = byte_cnt_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    byte_index_d = byte_index_q;

    case (state_q)
      S_IDLE: begin
        phase_d = 1'b0;
        if (start) begin
          state_d    = S_CMD;
          tx_d       = {CMD_BYTE, addr};
          len_d      = (len == 4'd0) ? 5'd16 : {1'b0, len};
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
        end
      end
      S_CMD, S_ADDR: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          tx_d      = {tx_q[30:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (state_q == S_CMD && bit_cnt_q == 5'd7) begin
            state_d   = S_ADDR;
            bit_cnt_d = '0;
          end else if (state_q == S_ADDR && bit_cnt_q == 5'd23) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
      end
      S_DATA: begin
        phase_d = ~phase_q;
        // The edge ending phase B is the sample point for io[1].
        if (phase_q) begin
          rx_d      = {rx_q[6:0], spi_in1};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q[2:0] == 3'd7) begin
            byte_valid_d = 1'b1;
            byte_data_d  = {rx_q[6:0], spi_in1};
            byte_index_d = byte_cnt_q[3:0];
            byte_cnt_d   = byte_cnt_q + 5'd1;
            if (byte_cnt_q + 5'd1 == len_q) state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        phase_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything, including a byte completing on the same edge.
    if (abort && state_q != S_IDLE) begin
      state_d      = S_IDLE;
      phase_d      = 1'b0;
      byte_valid_d = 1'b0;
      byte_data_d  = byte_data_q;
      byte_index_d = byte_index_q;
      byte_cnt_d   = byte_cnt_q;
      rx_d         = rx_q;
    end
  end

  logic tx_phase;
  assign tx_phase   = (state_q == S_CMD) || (state_q == S_ADDR);
  assign spi_cs     = tx_phase || (state_q == S_DATA);
  assign spi_sclk   = spi_cs && phase_q;
  assign spi_out0   = tx_phase && tx_q[31];
  assign spi_dir0   = ~tx_phase;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign byte_index = byte_index_q;

endmodule

// File: tb/tb_spi_read_fetcher.sv
// Directed bench for spi_read_fetcher with a cycle-position model of the
// expected pin activity and a flash responder on io[1].
module tb_spi_read_fetcher;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, spi_in1;
  logic [23:0] addr;
  logic [3:0]  len;
  logic        busy, done, byte_valid, spi_cs, spi_sclk, spi_out0, spi_dir0;
  logic [7:0]  byte_data;
  logic [3:0]  byte_index;

  spi_read_fetcher dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .len(len),
    .abort(abort), .busy(busy), .done(done), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_index(byte_index), .spi_cs(spi_cs),
    .spi_sclk(spi_sclk), .spi_out0(spi_out0), .spi_dir0(spi_dir0),
    .spi_in1(spi_in1)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;
  // Model: transaction active, position mc (1 = first CMD cycle), byte count mn.
  bit          mact = 1'b0;
  int          mc = 0, mn = 0;
  logic [31:0] mword = '0;
  logic [7:0]  exp_bd = '0;
  logic [3:0]  exp_bi = '0;
  logic [7:0]  flash [16];
  int          nvalid = 0, ndone = 0, done_cyc = 0;
  logic [7:0]  got_d [$];
  logic [3:0]  got_i [$];
  logic [31:0] mosi_word = '0;
  int          nbit = 0;

  // Flash responder: presents data bit for the whole bit period, records MOSI.
  always @(negedge clk) begin
    if (!spi_cs) begin
      nbit = 0;
      spi_in1 = 1'b0;
    end else begin
      if (nbit >= 32 && nbit < 160) spi_in1 = flash[(nbit - 32) / 8][7 - (nbit - 32) % 8];
      if (spi_sclk) begin
        if (nbit < 32) mosi_word = {mosi_word[30:0], spi_out0};
        nbit++;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {13'b0, busy, done, byte_valid, byte_data, byte_index,
            spi_cs, spi_sclk, spi_out0, spi_dir0};
  endfunction

  task automatic compare_step();
    logic e_busy, e_done, e_bv, e_cs, e_sclk, e_out, e_dir;
    int k;
    e_busy = 0; e_done = 0; e_bv = 0; e_cs = 0; e_sclk = 0; e_out = 0; e_dir = 1;
    if (!rst_n) begin
      exp_bd = '0;
      exp_bi = '0;
    end else if (mact) begin
      e_busy = 1;
      e_cs   = (mc <= 64 + 16 * mn);
      e_sclk = e_cs && (mc % 2 == 0);
      if (mc <= 64) begin
        e_dir = 0;
        e_out = mword[31 - (mc - 1) / 2];
      end
      e_done = (mc == 65 + 16 * mn);
      if (mc >= 81 && (mc - 81) % 16 == 0) begin
        k = (mc - 81) / 16;
        if (k < mn) begin
          e_bv   = 1;
          exp_bd = flash[k];
          exp_bi = 4'(k);
        end
      end
    end
    chk("cycle_outputs", outs(),
        {13'b0, e_busy, e_done, e_bv, exp_bd, exp_bi, e_cs, e_sclk, e_out, e_dir});
    if (byte_valid === 1'b1) begin
      nvalid++;
      got_d.push_back(byte_data);
      got_i.push_back(byte_index);
    end
    if (done === 1'b1) begin
      ndone++;
      done_cyc = cyc;
    end
  endtask

  task automatic model_step();
    if (!rst_n) return;
    cyc++;
    if (!mact) begin
      if (start) begin
        mact  = 1'b1;
        mc    = 1;
        mn    = (len == 4'd0) ? 16 : int'(len);
        mword = {8'h03, addr};
      end
    end else if (abort || mc == 65 + 16 * mn) begin
      mact = 1'b0;
    end else begin
      mc++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_step();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic wait_done(input int d0, input int bound);
    for (int i = 0; i < bound; i++) begin
      tick();
      if (ndone != d0) break;
    end
    chk("done_seen", 32'(ndone - d0), 32'd1);
  endtask

  int t_start, v0, d0, q0;

  task automatic begin_txn(input logic [23:0] a, input logic [3:0] l);
    v0 = nvalid; d0 = ndone; q0 = got_d.size();
    start = 1'b1; addr = a; len = l; t_start = cyc;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; addr = '0; len = '0;
    #1;
    chk("reset_outputs", outs(), 32'h0000_0001);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Basic read of two bytes.
    flash[0] = 8'hA5; flash[1] = 8'h3C;
    begin_txn(24'h123456, 4'd2);
    wait_done(d0, 200);
    chk("done_latency", 32'(done_cyc - t_start), 32'd97);
    chk("t1_nvalid", 32'(nvalid - v0), 32'd2);
    chk("t1_mosi", mosi_word, 32'h03123456);
    if (got_d.size() >= q0 + 2) begin
      chk("t1_b0", {24'b0, got_d[q0]}, 32'hA5);
      chk("t1_i0", {28'b0, got_i[q0]}, 32'd0);
      chk("t1_b1", {24'b0, got_d[q0 + 1]}, 32'h3C);
      chk("t1_i1", {28'b0, got_i[q0 + 1]}, 32'd1);
    end

    // Back-to-back start in the cycle right after done.
    flash[0] = 8'h5A;
    begin_txn(24'hABCDEF, 4'd1);
    chk("restart_cs", {31'b0, spi_cs}, 32'd1);
    wait_done(d0, 200);
    chk("t2_mosi", mosi_word, 32'h03ABCDEF);
    chk("t2_nvalid", 32'(nvalid - v0), 32'd1);

    // len=0 reads 16 bytes.
    for (int i = 0; i < 16; i++) flash[i] = 8'(8'h40 + i);
    repeat (2) tick();
    begin_txn(24'h000010, 4'd0);
    wait_done(d0, 700);
    chk("t3_nvalid", 32'(nvalid - v0), 32'd16);
    if (got_d.size() >= q0 + 16) begin
      chk("t3_last_data", {24'b0, got_d[q0 + 15]}, 32'h4F);
      chk("t3_last_idx", {28'b0, got_i[q0 + 15]}, 32'd15);
    end
    repeat (3) tick();
    chk("t3_ndone", 32'(ndone - d0), 32'd1);

    // Abort during ADDR bit 10.
    begin_txn(24'h0F0F0F, 4'd4);
    repeat (36) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_cs", {31'b0, spi_cs}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    repeat (150) tick();
    chk("abort_nvalid", 32'(nvalid - v0), 32'd0);
    chk("abort_ndone", 32'(ndone - d0), 32'd0);

    // Abort coinciding with the final sample suppresses that byte and done.
    begin_txn(24'h000200, 4'd1);
    repeat (79) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (20) tick();
    chk("abort_last_nvalid", 32'(nvalid - v0), 32'd0);
    chk("abort_last_ndone", 32'(ndone - d0), 32'd0);

    // Abort in IDLE does nothing.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();

    // Start pulsed during DATA is ignored.
    begin_txn(24'h000100, 4'd3);
    repeat (70) tick();
    start = 1'b1; addr = 24'h0; len = 4'd7;
    tick();
    start = 1'b0;
    wait_done(d0, 200);
    repeat (20) tick();
    chk("ign_nvalid", 32'(nvalid - v0), 32'd3);
    chk("ign_ndone", 32'(ndone - d0), 32'd1);

    // Reset asserted mid-DATA acts without a clock edge.
    begin_txn(24'h000300, 4'd2);
    repeat (70) tick();
    rst_n = 1'b0;
    mact = 1'b0;
    #1;
    chk("rst_mid_outputs", outs(), 32'h0000_0001);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    chk("rst_no_resume", 32'(ndone - d0), 32'd0);
    flash[0] = 8'hC3;
    begin_txn(24'h000400, 4'd1);
    wait_done(d0, 200);
    chk("post_rst_nvalid", 32'(nvalid - v0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
